// File: rtl/bitslice_alu_n.sv
// WIDTH-bit ALU slice with an NREGS-entry two-port register file and a Q register.
// The RAM/Q shifter supports up and down shifts. Overflow is computed from the carries.
// A shift-add unsigned multiplier processes one multiplier bit per clock and uses a
// start/busy/done handshake.
module bitslice_alu_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16,
  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  input  logic [AW-1:0]    i_a_sel,
  input  logic [AW-1:0]    i_b_sel,
  input  logic [2:0]       i_alu_src,
  input  logic [2:0]       i_alu_op,
  input  logic [2:0]       i_alu_dest,
  input  logic             i_cin,
  input  logic             i_q_lsb_in,
  input  logic             i_ram_lsb_in,
  input  logic             i_q_msb_in,
  input  logic             i_ram_msb_in,
  input  logic             i_mul_start,
  output logic             o_q_lsb_out,
  output logic             o_ram_lsb_out,
  output logic             o_q_msb_out,
  output logic             o_ram_msb_out,
  output logic [WIDTH-1:0] o_y_out,
  output logic             o_cout,
  output logic             o_fzero,
  output logic             o_fsign,
  output logic             o_ovr,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH:0]   r_acc;
  logic [AW-1:0]    r_dst;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_a, w_b, w_r, w_s, w_rop, w_sop, w_f, w_y;
  logic [WIDTH:0]   w_sum;
  logic             w_c_msb, w_cout, w_ovr;
  logic             w_reg_we, w_q_we, w_exec;
  logic [WIDTH-1:0] w_reg_wdata, w_q_wdata;
  logic [WIDTH:0]   w_mul_sum, w_acc_next;
  logic [WIDTH-1:0] w_q_mul_next;
  logic             w_mul_last;

  assign w_a = r_regs[i_a_sel];
  assign w_b = r_regs[i_b_sel];

  // R/S operand selection
  always_comb begin
    w_r = '0;
    w_s = '0;
    unique case (i_alu_src)
      3'd0: begin w_r = w_a;   w_s = r_q; end
      3'd1: begin w_r = w_a;   w_s = w_b; end
      3'd2: begin w_r = '0;    w_s = r_q; end
      3'd3: begin w_r = '0;    w_s = w_b; end
      3'd4: begin w_r = '0;    w_s = w_a; end
      3'd5: begin w_r = i_din; w_s = w_a; end
      3'd6: begin w_r = i_din; w_s = r_q; end
      3'd7: begin w_r = i_din; w_s = '0;  end
      default: ;
    endcase
  end

  // Subtracts invert one operand; cin supplies the +1
  always_comb begin
    w_rop = w_r;
    w_sop = w_s;
    if (i_alu_op == 3'd1) w_rop = ~w_r;
    if (i_alu_op == 3'd2) w_sop = ~w_s;
  end

  assign w_sum   = {1'b0, w_rop} + {1'b0, w_sop} + {{WIDTH{1'b0}}, i_cin};
  // Carry into the MSB recovered from the MSB sum bit and its operand bits
  assign w_c_msb = w_sum[WIDTH-1] ^ w_rop[WIDTH-1] ^ w_sop[WIDTH-1];

  // ALU function and arithmetic flags
  always_comb begin
    w_f    = w_sum[WIDTH-1:0];
    w_cout = w_sum[WIDTH];
    w_ovr  = w_c_msb ^ w_sum[WIDTH];
    case (i_alu_op)
      3'd3: begin w_f = w_r | w_s;     w_cout = 1'b0; w_ovr = 1'b0; end
      3'd4: begin w_f = w_r & w_s;     w_cout = 1'b0; w_ovr = 1'b0; end
      3'd5: begin w_f = ~w_r & w_s;    w_cout = 1'b0; w_ovr = 1'b0; end
      3'd6: begin w_f = w_r ^ w_s;     w_cout = 1'b0; w_ovr = 1'b0; end
      3'd7: begin w_f = ~(w_r ^ w_s);  w_cout = 1'b0; w_ovr = 1'b0; end
      default: ;
    endcase
  end

  // Destination decode: Y source, register/Q write data and shifts
  always_comb begin
    w_y         = w_f;
    w_reg_we    = 1'b0;
    w_q_we      = 1'b0;
    w_reg_wdata = w_f;
    w_q_wdata   = w_f;
    unique case (i_alu_dest)
      3'd0: w_q_we = 1'b1;
      3'd1: ;
      3'd2: begin w_reg_we = 1'b1; w_y = w_a; end
      3'd3: w_reg_we = 1'b1;
      3'd4: begin
        w_reg_we    = 1'b1;
        w_q_we      = 1'b1;
        w_reg_wdata = {i_ram_msb_in, w_f[WIDTH-1:1]};
        w_q_wdata   = {i_q_msb_in, r_q[WIDTH-1:1]};
      end
      3'd5: begin
        w_reg_we    = 1'b1;
        w_reg_wdata = {i_ram_msb_in, w_f[WIDTH-1:1]};
      end
      3'd6: begin
        w_reg_we    = 1'b1;
        w_q_we      = 1'b1;
        w_reg_wdata = {w_f[WIDTH-2:0], i_ram_lsb_in};
        w_q_wdata   = {r_q[WIDTH-2:0], i_q_lsb_in};
      end
      3'd7: begin
        w_reg_we    = 1'b1;
        w_reg_wdata = {w_f[WIDTH-2:0], i_ram_lsb_in};
      end
      default: ;
    endcase
  end

  // Multiply step: conditional add, then shift {acc, Q} right by one
  assign w_mul_sum    = r_acc + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_acc_next   = {1'b0, w_mul_sum[WIDTH:1]};
  assign w_q_mul_next = {w_mul_sum[0], r_q[WIDTH-1:1]};
  assign w_mul_last   = (r_state == StMul) && (r_cnt == CW'(WIDTH - 1));

  // mul_start takes priority over a normal instruction in the same cycle
  assign w_exec = i_en && (r_state == StIdle) && !i_mul_start;

  // FSM state register
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_mul_start) w_state_next = StMul;
      StMul:   if (w_mul_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (r_state != StIdle);
    o_done = (r_state == StDone);
  end

  // Register file, Q and multiplier datapath state
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_acc <= '0;
      r_dst <= '0;
      r_cnt <= '0;
    end else if (r_state == StIdle && i_mul_start) begin
      r_m   <= w_a;
      r_dst <= i_b_sel;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == StMul) begin
      r_acc <= w_acc_next;
      r_q   <= w_q_mul_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_mul_last) r_regs[r_dst] <= w_acc_next[WIDTH-1:0];
    end else if (w_exec) begin
      if (w_q_we)   r_q <= w_q_wdata;
      if (w_reg_we) r_regs[i_b_sel] <= w_reg_wdata;
    end
  end

  assign o_y_out       = o_busy ? r_acc[WIDTH-1:0] : w_y;
  assign o_cout        = w_cout;
  assign o_ovr         = w_ovr;
  assign o_fzero       = (w_f == '0);
  assign o_fsign       = w_f[WIDTH-1];
  assign o_q_lsb_out   = r_q[0];
  assign o_q_msb_out   = r_q[WIDTH-1];
  assign o_ram_lsb_out = w_f[0];
  assign o_ram_msb_out = w_f[WIDTH-1];

endmodule

// File: tb/tb_bitslice_alu_n.sv
// Self-checking bench for bitslice_alu_n (WIDTH=16, NREGS=16): fixed vector table,
// hand-written multiply sequences, and randomized ops against an arithmetic model.
module tb_bitslice_alu_n;

  logic        clk = 1'b0;
  logic        rst_n, en, cin, mul_start;
  logic        q_lsb_in, ram_lsb_in, q_msb_in, ram_msb_in;
  logic [15:0] din;
  logic [3:0]  a_sel, b_sel;
  logic [2:0]  src, op, dest;
  logic        q_lsb_out, ram_lsb_out, q_msb_out, ram_msb_out;
  logic [15:0] y;
  logic        cout, fzero, fsign, ovr, busy, done;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [16];
  logic [15:0] m_q;

  always #5 clk = ~clk;

  bitslice_alu_n #(.WIDTH(16), .NREGS(16)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_en(en), .i_din(din),
    .i_a_sel(a_sel), .i_b_sel(b_sel), .i_alu_src(src), .i_alu_op(op),
    .i_alu_dest(dest), .i_cin(cin), .i_q_lsb_in(q_lsb_in), .i_ram_lsb_in(ram_lsb_in),
    .i_q_msb_in(q_msb_in), .i_ram_msb_in(ram_msb_in), .i_mul_start(mul_start),
    .o_q_lsb_out(q_lsb_out), .o_ram_lsb_out(ram_lsb_out), .o_q_msb_out(q_msb_out),
    .o_ram_msb_out(ram_msb_out), .o_y_out(y), .o_cout(cout), .o_fzero(fzero),
    .o_fsign(fsign), .o_ovr(ovr), .o_busy(busy), .o_done(done)
  );

  typedef struct {
    logic        en;
    logic [2:0]  src, op, dest;
    logic        cin;
    logic [3:0]  fills;  // {q_lsb_in, ram_lsb_in, q_msb_in, ram_msb_in}
    logic [15:0] din;
    logic [3:0]  a, b;
    logic [15:0] y;
    logic [3:0]  fl;     // {cout, ovr, fzero, fsign}
    logic [3:0]  sh;     // {q_msb_out, q_lsb_out, ram_msb_out, ram_lsb_out}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic [2:0] s, o, d, input logic c,
                              input logic [3:0] f, input logic [15:0] dv,
                              input logic [3:0] a, b, input logic [15:0] ey,
                              input logic [3:0] efl, esh);
    vec_t v;
    v.en = e; v.src = s; v.op = o; v.dest = d; v.cin = c; v.fills = f; v.din = dv;
    v.a = a; v.b = b; v.y = ey; v.fl = efl; v.sh = esh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [2:0] s, o, d, input logic c,
                       input logic [3:0] f, input logic [15:0] dv, input logic [3:0] a, b);
    en = e; src = s; op = o; dest = d; cin = c; din = dv; a_sel = a; b_sel = b;
    {q_lsb_in, ram_lsb_in, q_msb_in, ram_msb_in} = f;
    mul_start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [3:0] idx, input logic [15:0] exp, input string name);
    drive(1'b0, 3'd4, 3'd0, 3'd1, 1'b0, 4'd0, 16'd0, idx, 4'd0);
    #1;
    chk(name, {16'd0, y}, {16'd0, exp});
    tick();
  endtask

  task automatic read_q(input logic [15:0] exp, input string name);
    drive(1'b0, 3'd2, 3'd0, 3'd1, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0);
    #1;
    chk(name, {16'd0, y}, {16'd0, exp});
    tick();
  endtask

  task automatic load_reg(input logic [3:0] idx, input logic [15:0] val);
    drive(1'b1, 3'd7, 3'd0, 3'd3, 1'b0, 4'd0, val, 4'd0, idx);
    tick();
  endtask

  task automatic load_q(input logic [15:0] val);
    drive(1'b1, 3'd7, 3'd0, 3'd0, 1'b0, 4'd0, val, 4'd0, 4'd0);
    tick();
  endtask

  // Start a multiply and track the handshake; junk instructions are driven while busy.
  task automatic do_mul(input logic [3:0] a, b, input logic [15:0] exp_hi);
    int nb = 0;
    int dat = 0;
    // Co-issued Q write must be dropped in favour of the multiply
    drive(1'b1, 3'd7, 3'd0, 3'd0, 1'b0, 4'd0, 16'h5555, a, b);
    mul_start = 1'b1;
    tick();
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      nb++;
      if (done === 1'b1) begin
        dat = nb;
        chk("mul_y_at_done", {16'd0, y}, {16'd0, exp_hi});
      end
      drive(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'b0, 4'($urandom_range(0, 15)),
            16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      mul_start = 1'($urandom_range(0, 1));
      tick();
    end
    drive(1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0);
    chk("mul_busy_cycles", nb, 17);
    chk("mul_done_at", dat, 17);
  endtask

  function automatic int sx(input int unsigned x);
    return (x >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  // Reference model: expected outputs from pre-edge state, then commits the write if en.
  task automatic model_op(input logic e, input logic [2:0] s, o, d, input logic c,
                          input logic [3:0] f, input logic [15:0] dv, input logic [3:0] a, b,
                          output logic [15:0] ey, output logic [3:0] efl,
                          output logic [3:0] esh);
    int unsigned av, bv, qv, r, sv, rr, ss, fv, tot;
    int          sgn;
    logic        co, ov;
    av = m_regs[a]; bv = m_regs[b]; qv = m_q;
    case (s)
      3'd0: begin r = av; sv = qv; end
      3'd1: begin r = av; sv = bv; end
      3'd2: begin r = 0;  sv = qv; end
      3'd3: begin r = 0;  sv = bv; end
      3'd4: begin r = 0;  sv = av; end
      3'd5: begin r = dv; sv = av; end
      3'd6: begin r = dv; sv = qv; end
      default: begin r = dv; sv = 0; end
    endcase
    co = 1'b0; ov = 1'b0;
    if (o < 3) begin
      rr  = (o == 3'd1) ? (~r & 32'hFFFF) : r;
      ss  = (o == 3'd2) ? (~sv & 32'hFFFF) : sv;
      tot = rr + ss + c;
      fv  = tot % 65536;
      co  = (tot >= 65536);
      sgn = sx(rr) + sx(ss) + int'(c);
      ov  = (sgn > 32767) || (sgn < -32768);
    end else begin
      case (o)
        3'd3: fv = r | sv;
        3'd4: fv = r & sv;
        3'd5: fv = ~r & sv & 32'hFFFF;
        3'd6: fv = r ^ sv;
        default: fv = ~(r ^ sv) & 32'hFFFF;
      endcase
    end
    ey  = (d == 3'd2) ? 16'(av) : 16'(fv);
    efl = {co, ov, fv == 0, fv >= 32768};
    esh = {qv >= 32768, qv % 2 == 1, fv >= 32768, fv % 2 == 1};
    if (e) begin
      case (d)
        3'd0: m_q = 16'(fv);
        3'd2, 3'd3: m_regs[b] = 16'(fv);
        3'd4: begin
          m_regs[b] = 16'(fv / 2 + f[0] * 32768);
          m_q       = 16'(qv / 2 + f[1] * 32768);
        end
        3'd5: m_regs[b] = 16'(fv / 2 + f[0] * 32768);
        3'd6: begin
          m_regs[b] = 16'((fv * 2) % 65536 + f[2]);
          m_q       = 16'((qv * 2) % 65536 + f[3]);
        end
        3'd7: m_regs[b] = 16'((fv * 2) % 65536 + f[2]);
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [15:0] ey;
    logic [3:0]  efl, esh;
    longint unsigned prod;

    drive(1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    for (int i = 0; i < 16; i++) read_reg(4'(i), 16'h0000, $sformatf("rst_r%0d", i));
    read_q(16'h0000, "rst_q");

    // Table: en src op dest cin fills din a b | y {cout,ovr,fz,fs} {qm,ql,rm,rl}
    vecs.push_back(mk(1, 7, 0, 3, 0, 4'b0000, 16'h7FFF, 0, 1, 16'h7FFF, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 7, 0, 3, 0, 4'b0000, 16'h0001, 0, 2, 16'h0001, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 1, 0, 3, 0, 4'b0000, 16'h0000, 1, 2, 16'h8000, 4'b0101, 4'b0010));
    vecs.push_back(mk(1, 4, 0, 1, 0, 4'b0000, 16'h0000, 2, 0, 16'h8000, 4'b0001, 4'b0010));
    vecs.push_back(mk(1, 7, 0, 3, 0, 4'b0000, 16'h0000, 0, 1, 16'h0000, 4'b0010, 4'b0000));
    vecs.push_back(mk(1, 7, 0, 3, 0, 4'b0000, 16'h0001, 0, 2, 16'h0001, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 1, 2, 1, 1, 4'b0000, 16'h0000, 1, 2, 16'hFFFF, 4'b0001, 4'b0011));
    vecs.push_back(mk(1, 1, 2, 1, 1, 4'b0000, 16'h0000, 2, 2, 16'h0000, 4'b1010, 4'b0000));
    vecs.push_back(mk(1, 1, 1, 1, 1, 4'b0000, 16'h0000, 2, 1, 16'hFFFF, 4'b0001, 4'b0011));
    vecs.push_back(mk(1, 7, 0, 0, 0, 4'b0000, 16'h8001, 0, 0, 16'h8001, 4'b0001, 4'b0011));
    vecs.push_back(mk(1, 2, 0, 4, 0, 4'b0010, 16'h0000, 0, 3, 16'h8001, 4'b0001, 4'b1111));
    vecs.push_back(mk(1, 2, 0, 1, 0, 4'b0000, 16'h0000, 0, 0, 16'hC000, 4'b0001, 4'b1010));
    vecs.push_back(mk(1, 4, 0, 1, 0, 4'b0000, 16'h0000, 3, 0, 16'h4000, 4'b0000, 4'b1000));
    vecs.push_back(mk(1, 7, 0, 0, 0, 4'b0000, 16'h8001, 0, 0, 16'h8001, 4'b0001, 4'b1011));
    vecs.push_back(mk(1, 2, 0, 6, 0, 4'b0100, 16'h0000, 0, 5, 16'h8001, 4'b0001, 4'b1111));
    vecs.push_back(mk(1, 2, 0, 1, 0, 4'b0000, 16'h0000, 0, 0, 16'h0002, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4, 0, 1, 0, 4'b0000, 16'h0000, 5, 0, 16'h0003, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 5, 3, 2, 0, 4'b0000, 16'h00F0, 5, 6, 16'h0003, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 4, 0, 1, 0, 4'b0000, 16'h0000, 6, 0, 16'h00F3, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 6, 7, 1, 1, 4'b0000, 16'h0002, 0, 0, 16'hFFFF, 4'b0001, 4'b0011));
    vecs.push_back(mk(1, 1, 5, 1, 0, 4'b0000, 16'h0000, 6, 5, 16'h0000, 4'b0010, 4'b0000));
    vecs.push_back(mk(1, 1, 4, 1, 0, 4'b0000, 16'h0000, 6, 5, 16'h0003, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 1, 6, 1, 0, 4'b0000, 16'h0000, 6, 5, 16'h00F0, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, 7, 0, 3, 0, 4'b0000, 16'h1234, 0, 1, 16'h1234, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4, 0, 1, 0, 4'b0000, 16'h0000, 1, 0, 16'h0000, 4'b0010, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].src, vecs[i].op, vecs[i].dest, vecs[i].cin, vecs[i].fills,
            vecs[i].din, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("row%0d_y", i), {16'd0, y}, {16'd0, vecs[i].y});
      chk($sformatf("row%0d_flags", i), {28'd0, cout, ovr, fzero, fsign}, {28'd0, vecs[i].fl});
      chk($sformatf("row%0d_shift", i),
          {28'd0, q_msb_out, q_lsb_out, ram_msb_out, ram_lsb_out}, {28'd0, vecs[i].sh});
      tick();
    end

    // FFFF x FFFF, with writes attempted while busy
    load_reg(4'd3, 16'hFFFF);
    load_q(16'hFFFF);
    do_mul(4'd3, 4'd4, 16'hFFFE);
    read_reg(4'd4, 16'hFFFE, "mul_ffff_hi");
    read_q(16'h0001, "mul_ffff_lo");
    read_reg(4'd3, 16'hFFFF, "mul_ffff_src_kept");

    // Reset in the middle of a multiply
    begin
      int ndone = 0;
      load_reg(4'd1, 16'h1234);
      load_reg(4'd2, 16'h9999);
      load_q(16'h5678);
      drive(1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 4'd0, 16'd0, 4'd1, 4'd2);
      mul_start = 1'b1;
      tick();
      mul_start = 1'b0;
      for (int c = 0; c < 7; c++) tick();
      chk("abort_busy_before", {31'd0, busy}, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_done", {31'd0, done}, 0);
      for (int c = 0; c < 20; c++) begin
        if (done === 1'b1) ndone++;
        tick();
      end
      chk("abort_no_done", ndone, 0);
      read_reg(4'd2, 16'h0000, "abort_dst");
      read_q(16'h0000, "abort_q");
    end

    // Randomized ops and multiplies against the model
    drive(1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_q = 16'h0000;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        logic [3:0] ra, rb;
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        prod = longint'(m_regs[ra]) * longint'(m_q);
        do_mul(ra, rb, 16'(prod >> 16));
        m_regs[rb] = 16'(prod >> 16);
        m_q = 16'(prod);
        read_reg(rb, m_regs[rb], "rnd_mul_hi");
        read_q(m_q, "rnd_mul_lo");
      end else begin
        logic       re, rc;
        logic [2:0] rs, ro, rd;
        logic [3:0] rf, ra, rb;
        logic [15:0] rdv;
        re = ($urandom_range(0, 3) != 0);
        rs = 3'($urandom_range(0, 7));
        ro = 3'($urandom_range(0, 7));
        rd = 3'($urandom_range(0, 7));
        rc = 1'($urandom_range(0, 1));
        rf = 4'($urandom_range(0, 15));
        rdv = 16'($urandom);
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        model_op(re, rs, ro, rd, rc, rf, rdv, ra, rb, ey, efl, esh);
        drive(re, rs, ro, rd, rc, rf, rdv, ra, rb);
        #1;
        chk($sformatf("rnd%0d_y", it), {16'd0, y}, {16'd0, ey});
        chk($sformatf("rnd%0d_flags", it), {28'd0, cout, ovr, fzero, fsign}, {28'd0, efl});
        chk($sformatf("rnd%0d_shift", it),
            {28'd0, q_msb_out, q_lsb_out, ram_msb_out, ram_lsb_out}, {28'd0, esh});
        tick();
      end
    end
    for (int i = 0; i < 16; i++) read_reg(4'(i), m_regs[i], $sformatf("final_r%0d", i));
    read_q(m_q, "final_q");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
